// File: rtl/dispatch_scheduler.sv
// Dispatch controller: per-station RS credits, ROB allocation/occupancy, decode stall, flush recovery.
// Optional stall-cycle performance counter enabled by defining DISPATCH_PERF_EN.
module dispatch_scheduler #(
  parameter int ROB      = 2,
  parameter int RS       = 1,
  parameter int RSDEPTH  = 4,
  parameter int FLUSHCYC = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  decValid,
  input  logic [RS:0]           RSstation,
  input  logic [2**(RS+1)-1:0]  rsRelease,
  input  logic                  robCommit,
  output logic                  dispatch,
  output logic [2**(RS+1)-1:0]  dispatchStation,
  output logic [ROB:0]          robTag,
  output logic                  stall,
  output logic [ROB+1:0]        robCount,
  output logic                  creditErr
`ifdef DISPATCH_PERF_EN
  ,
  output logic [15:0]           stallCycles
`endif
);

  localparam int NST = 2**(RS+1);
  localparam logic [ROB+1:0] ROB_FULL = (ROB+2)'(2**(ROB+1));
  localparam logic [3:0]     CRED_MAX = 4'(RSDEPTH);
  localparam logic [2:0]     RC_INIT  = 3'(FLUSHCYC-1);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t         r_state, w_state_nxt;
  logic [2:0]     r_rc, w_rc_nxt;
  logic [3:0]     r_cred [NST];
  logic [3:0]     w_cred_nxt [NST];
  logic [ROB:0]   r_tail, w_tail_nxt;
  logic [ROB+1:0] r_robCount, w_count_nxt;
  logic           r_creditErr, w_err_set;
  logic [NST-1:0] w_sel, w_dec;
  logic           w_grant;

  always_comb begin
    w_sel = '0;
    w_sel[RSstation] = 1'b1;
  end

  // A flush in the same cycle blocks the grant so no tag is handed out across the flush.
  assign w_grant = decValid & ~flush & (r_state == RUN)
                 & (r_cred[RSstation] != 4'd0) & (r_robCount != ROB_FULL);
  assign w_dec   = w_grant ? w_sel : '0;

  assign dispatch        = w_grant;
  assign dispatchStation = w_dec;
  assign robTag          = r_tail;
  assign stall           = decValid & ~w_grant & ~flush & (r_state == RUN);
  assign robCount        = r_robCount;
  assign creditErr       = r_creditErr;

  always_comb begin
    w_state_nxt = r_state;
    w_rc_nxt    = r_rc;
    w_cred_nxt  = r_cred;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_robCount;
    w_err_set   = 1'b0;
    if (flush) begin
      w_state_nxt = RECOVER;
      w_rc_nxt    = RC_INIT;
      for (int s = 0; s < NST; s++) w_cred_nxt[s] = CRED_MAX;
      w_tail_nxt  = '0;
      w_count_nxt = '0;
    end else if (r_state == RECOVER) begin
      if (r_rc == 3'd0) w_state_nxt = RUN;
      else              w_rc_nxt    = r_rc - 3'd1;
    end else begin
      for (int s = 0; s < NST; s++) begin
        if (rsRelease[s] && !w_dec[s] && (r_cred[s] == CRED_MAX))
          w_err_set = 1'b1;
        else
          w_cred_nxt[s] = r_cred[s] + {3'b000, rsRelease[s]} - {3'b000, w_dec[s]};
      end
      if (robCommit && !w_grant && (r_robCount == '0))
        w_err_set = 1'b1;
      else
        w_count_nxt = r_robCount + {{(ROB+1){1'b0}}, w_grant}
                                 - {{(ROB+1){1'b0}}, robCommit};
      w_tail_nxt = r_tail + {{ROB{1'b0}}, w_grant};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_rc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rc    <= w_rc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < NST; s++) r_cred[s] <= CRED_MAX;
      r_tail      <= '0;
      r_robCount  <= '0;
      r_creditErr <= 1'b0;
    end else begin
      for (int s = 0; s < NST; s++) r_cred[s] <= w_cred_nxt[s];
      r_tail      <= w_tail_nxt;
      r_robCount  <= w_count_nxt;
      r_creditErr <= r_creditErr | w_err_set;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [15:0] r_stallCycles;

  always_ff @(posedge clk) begin
    if (!reset || flush)
      r_stallCycles <= '0;
    else if (stall && (r_stallCycles != 16'hFFFF))
      r_stallCycles <= r_stallCycles + 16'd1;
  end

  assign stallCycles = r_stallCycles;
`endif

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Scoreboard bench for dispatch_scheduler: a behavioural model queues expected outputs per cycle.
module tb_dispatch_scheduler;

  localparam int FLUSHCYC = 2;
  localparam int RSDEPTH  = 4;
  localparam int ROBN     = 8;

  logic       clk = 1'b0;
  logic       reset, flush, decValid, robCommit;
  logic [1:0] RSstation;
  logic [3:0] rsRelease;
  logic       dispatch, stall, creditErr;
  logic [3:0] dispatchStation;
  logic [2:0] robTag;
  logic [3:0] robCount;
`ifdef DISPATCH_PERF_EN
  logic [15:0] stallCycles;
`endif

  dispatch_scheduler #(.ROB(2), .RS(1), .RSDEPTH(RSDEPTH), .FLUSHCYC(FLUSHCYC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .decValid(decValid),
    .RSstation(RSstation), .rsRelease(rsRelease), .robCommit(robCommit),
    .dispatch(dispatch), .dispatchStation(dispatchStation), .robTag(robTag),
    .stall(stall), .robCount(robCount), .creditErr(creditErr)
`ifdef DISPATCH_PERF_EN
    , .stallCycles(stallCycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       disp;
    logic [3:0] dst;
    logic [2:0] tag;
    logic       stl;
    logic [3:0] cnt;
    logic       err;
    int         sc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  int m_cred [4];
  int m_tail, m_cnt, m_rec, m_sc;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_init();
    for (int s = 0; s < 4; s++) m_cred[s] = RSDEPTH;
    m_tail = 0; m_cnt = 0; m_rec = 0; m_err = 0; m_sc = 0;
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic step(input logic dv, input logic [1:0] st, input logic [3:0] rel,
                      input logic com, input logic fl);
    exp_t e, o;
    bit g;
    decValid = dv; RSstation = st; rsRelease = rel; robCommit = com; flush = fl;
    g = dv && !fl && (m_rec == 0) && (m_cred[st] > 0) && (m_cnt < ROBN);
    e.disp = g;
    e.dst  = g ? (4'b0001 << st) : 4'b0000;
    e.tag  = 3'(m_tail);
    e.stl  = dv && !fl && (m_rec == 0) && !g;
    e.cnt  = 4'(m_cnt);
    e.err  = m_err;
    e.sc   = m_sc;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk("dispatch", {31'b0, dispatch}, {31'b0, o.disp});
    chk("dispStation", {28'b0, dispatchStation}, {28'b0, o.dst});
    chk("robTag", {29'b0, robTag}, {29'b0, o.tag});
    chk("stall", {31'b0, stall}, {31'b0, o.stl});
    chk("robCount", {28'b0, robCount}, {28'b0, o.cnt});
    chk("creditErr", {31'b0, creditErr}, {31'b0, o.err});
`ifdef DISPATCH_PERF_EN
    chk("stallCycles", {16'b0, stallCycles}, o.sc);
`endif
    // Advance the model across the coming edge
    if (fl) begin
      for (int s = 0; s < 4; s++) m_cred[s] = RSDEPTH;
      m_cnt = 0; m_tail = 0; m_rec = FLUSHCYC; m_sc = 0;
    end else if (m_rec > 0) begin
      m_rec--;
    end else begin
      if (e.stl && m_sc < 65535) m_sc++;
      for (int s = 0; s < 4; s++) begin
        bit d;
        d = g && (st == 2'(s));
        if (rel[s] && !d && m_cred[s] == RSDEPTH) m_err = 1;
        else m_cred[s] = m_cred[s] + int'(rel[s]) - int'(d);
      end
      if (com && !g && m_cnt == 0) m_err = 1;
      else m_cnt = m_cnt + int'(g) - int'(com);
      if (g) m_tail = (m_tail + 1) % ROBN;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; flush = 1'b0; decValid = 1'b0; RSstation = '0;
    rsRelease = '0; robCommit = 1'b0;
    @(posedge clk); #1;
    model_init();
    chk("rst_dispatch", {31'b0, dispatch}, 32'd0);
    chk("rst_dispStation", {28'b0, dispatchStation}, 32'd0);
    chk("rst_robTag", {29'b0, robTag}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_robCount", {28'b0, robCount}, 32'd0);
    chk("rst_creditErr", {31'b0, creditErr}, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] fill_st [8];
    fill_st = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    @(posedge clk); #1;

    // ALU credits exhaust after RSDEPTH grants
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 2'd0, 4'b0, 0, 0);
    chk("alu_empty_stall", {31'b0, stall}, 32'd1);

    // Fill ROB with per-station release, then commit and wrap the tag
    do_reset();
    for (int i = 0; i < 8; i++) step(1, fill_st[i], 4'b0001 << fill_st[i], 0, 0);
    chk("rob_full_cnt", {28'b0, robCount}, 32'd8);
    step(1, 2'd0, 4'b0, 0, 0);
    step(0, 2'd0, 4'b0, 1, 0);
    chk("wrap_tag", {29'b0, robTag}, 32'd0);
    step(1, 2'd0, 4'b0, 0, 0);

    // Same-cycle dispatch and release on station 2 at credit 1
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 2'd2, 4'b0, 0, 0);
    step(1, 2'd2, 4'b0100, 0, 0);
    step(1, 2'd2, 4'b0, 0, 0);
    step(1, 2'd2, 4'b0, 0, 0);

    // Flush with robCount=5 and decode valid
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 2'(i), 4'b0, 0, 0);
    chk("pre_flush_cnt", {28'b0, robCount}, 32'd5);
    step(1, 2'd1, 4'b0, 0, 1);
    for (int i = 0; i < FLUSHCYC; i++) step(1, 2'd1, 4'b0010, 1, 0);
    step(1, 2'd1, 4'b0, 0, 0);
    chk("post_flush_cnt", {28'b0, robCount}, 32'd1);

    // Illegal release and commit set the sticky error
    do_reset();
    step(0, 2'd0, 4'b0010, 1, 0);
    chk("err_set", {31'b0, creditErr}, 32'd1);
    step(1, 2'd1, 4'b0, 0, 0);
    step(0, 2'd0, 4'b0, 0, 1);
    step(0, 2'd0, 4'b0, 0, 0);
    chk("err_sticky", {31'b0, creditErr}, 32'd1);

    // Stall counter across a flush
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 2'd3, 4'b0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 2'd3, 4'b0, 0, 0);
`ifdef DISPATCH_PERF_EN
    chk("perf_three", {16'b0, stallCycles}, 32'd3);
`endif
    step(0, 2'd0, 4'b0, 0, 1);
`ifdef DISPATCH_PERF_EN
    chk("perf_cleared", {16'b0, stallCycles}, 32'd0);
`endif
    step(0, 2'd0, 4'b0, 0, 0);
    step(0, 2'd0, 4'b0, 0, 0);

    // Random traffic with occasional flushes
    do_reset();
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);

    // Reset mid-operation abandons recovery
    step(1, 2'd0, 4'b0, 0, 1);
    do_reset();
    step(1, 2'd0, 4'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dispatch_scheduler.md
# dispatch_scheduler

Dispatch controller between `instr_decode` and the back end. Each cycle it decides whether the decoded instruction can be dispatched. It tracks free reservation-station entries per station and free ROB entries with credit counters, allocates the ROB tag, and raises the stall that freezes decode. On a misprediction flush it restores all credits and runs a fixed-length recovery window.

## Interface
Parameters:
- `ROB`, 2 — ROB tag MSB index; ROB has 2^(ROB+1) entries (8).
- `RS`, 1 — station select MSB index; 2^(RS+1) stations (4: 0 ALU, 1 branch, 2 mem, 3 mult).
- `RSDEPTH`, 4 — entries per reservation station (1..15).
- `FLUSHCYC`, 2 — recovery cycles after flush (1..7).

Ports:
- `clk` in 1 — clock, rising edge.
- `reset` in 1 — synchronous, active-low reset.
- `flush` in 1 — misprediction/misdirect flush (robBus.controlFlow[0]).
- `decValid` in 1 — decoded instruction present (stationRequest).
- `RSstation` in RS+1 — target station.
- `rsRelease` in 2^(RS+1) — one bit per station; one entry freed this cycle.
- `robCommit` in 1 — ROB head retired this cycle.
- `dispatch` out 1 — instruction accepted this cycle.
- `dispatchStation` out 2^(RS+1) — one-hot station write enable.
- `robTag` out ROB+1 — ROB entry allocated to the dispatching instruction.
- `stall` out 1 — freeze fetch/decode; drives decode's fullRob.
- `robCount` out ROB+2 — occupied ROB entries.
- `creditErr` out 1 — sticky; set on a release to a full station or a commit with robCount 0.

## Operation
- State: per-station credit `cred[s]` (0..RSDEPTH); ROB tail pointer `tail`; `robCount`; FSM {RUN, RECOVER}; recovery counter `rc`.
- Grant, combinational: `grant = decValid & state==RUN & cred[RSstation]!=0 & robCount!=2^(ROB+1)`.
- Outputs:
  - `dispatch = grant`.
  - `dispatchStation = grant ? onehot(RSstation) : 0`.
  - `robTag = tail`, always driven.
  - `stall = decValid & !grant & state==RUN`. Stall is 0 in RECOVER so decode can clear its register.
- Credit update per station s: `cred[s] <= cred[s] - (grant & RSstation==s) + rsRelease[s]`.
  - Dispatch and release on the same station in the same cycle leave the credit unchanged.
  - A release at `cred==RSDEPTH` with no dispatch to that station is dropped and sets `creditErr`.
- ROB update: `robCount <= robCount + grant - robCommit`. A commit at `robCount==0` with no grant is dropped and sets `creditErr`. `tail` increments by 1 on grant, wrapping modulo 2^(ROB+1).
- FSM:
  - RUN → RECOVER on `flush`: all `cred` ← RSDEPTH, `robCount` ← 0, `tail` ← 0, `rc` ← FLUSHCYC-1.
  - RECOVER: `grant` forced 0; `rsRelease` and `robCommit` ignored; `rc` decrements each cycle; go to RUN when `rc==0`.
  - A `flush` seen in RECOVER reloads `rc` and reinitialises the counters.
- Priority: `reset` > `flush` > normal updates. A flush in the same cycle as decValid produces no grant.
- `creditErr` clears only on reset.

## Timing
- Grant, `dispatchStation`, `robTag` and `stall` are valid in the same cycle as decValid/RSstation, combinationally from registered state. No input-to-output path goes through rsRelease or robCommit.
- Counter, tail and FSM updates take effect at the next rising edge. A credit freed in cycle N is usable in cycle N+1.
- Flush latency: a flush in cycle N gives `dispatch=0` in cycles N..N+FLUSHCYC. The first possible grant is in cycle N+FLUSHCYC+1.
- Reset values: state RUN, `cred[*]`=RSDEPTH, `tail`=0, `robCount`=0, `rc`=0, `creditErr`=0. As a result, `dispatch`=0, `dispatchStation`=0, `robTag`=0 and `stall`=0 while decValid=0.
- Reset mid-operation: applied at the edge regardless of state; recovery is abandoned.

## Configuration
- `DISPATCH_PERF_EN` defined: adds output `stallCycles` (16 bits). It increments on every cycle with `stall`=1, saturates at 0xFFFF, and clears on reset and on flush.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- After reset, decValid=1, RSstation=0 for 5 cycles, no releases → grants in cycles 1–4 with robTag 0,1,2,3. In cycle 5, stall=1 and dispatch=0 (ALU credit 0).
- Fill the ROB: alternate stations 0–3, two each, release every station entry each cycle, no commits → 8 grants with tags 0..7, then stall=1 and robCount=8. A single robCommit → grant next cycle with tag 0 (wrap).
- Same-cycle dispatch to station 2 plus rsRelease[2] at cred[2]=1 → cred stays 1; next cycle grant again.
- Flush with robCount=5 and decValid=1, FLUSHCYC=2 → dispatch=0 that cycle and for the 2 following cycles, stall=0 throughout. Next grant has robTag 0, robCount goes 0→1.
- rsRelease[1] at full credit, robCommit at robCount=0 → creditErr=1, both counters unchanged. creditErr stays 1 until reset.
- With `DISPATCH_PERF_EN`: 3 stall cycles, then flush → stallCycles reads 3, then 0 after the flush edge.
